gcd_operand_sequencer: RTL

Upstream feeder for the GCD core. Buffers operand pairs in a small FIFO, presents each pair to the core, pulses its start input, waits for completion, and returns the pair plus result on a valid/ready output. Pairs containing a zero bypass the core, because subtractive GCD never terminates on zero. A completion timeout keeps a hung core from stalling the queue.

---
 rtl/gcd_operand_sequencer_pkg.sv | 19 +
 rtl/gcd_pair_fifo.sv | 57 +++++
 rtl/gcd_operand_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gcd_operand_sequencer_pkg.sv
// rtl/gcd_operand_sequencer_pkg.sv - shared state encoding and operand width for the GCD feeder
package gcd_operand_sequencer_pkg;

    localparam int OPW = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4
    } seq_state_t;

    // Subtractive GCD never terminates on a zero operand, so such pairs skip the core.
    function automatic logic has_zero(input logic [OPW-1:0] x, input logic [OPW-1:0] y);
        return (x == '0) || (y == '0);
    endfunction

endpackage

// File: rtl/gcd_pair_fifo.sv
// rtl/gcd_pair_fifo.sv - small synchronous FIFO holding packed operand pairs
module gcd_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// rtl/gcd_operand_sequencer.sv - queues operand pairs, drives the GCD core and returns results
module gcd_operand_sequencer
    import gcd_operand_sequencer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic [OPW-1:0] push_x,
    input  logic [OPW-1:0] push_y,
    output logic           full,
    output logic [OPW-1:0] gcd_x,
    output logic [OPW-1:0] gcd_y,
    output logic           gcd_start,
    input  logic           gcd_done,
    input  logic [OPW-1:0] gcd_result,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [OPW-1:0] res_x,
    output logic [OPW-1:0] res_y,
    output logic [OPW-1:0] res_gcd,
    output logic           res_err,
    output logic           busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    seq_state_t       state;
    logic [OPW-1:0]   op_x;
    logic [OPW-1:0]   op_y;
    logic             done_prev;
    logic [TW-1:0]    tmo_cnt;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [2*OPW-1:0] fifo_rdata;
    logic             done_edge;

    gcd_pair_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * OPW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_x, push_y}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (full),
        .empty     (fifo_empty)
    );

    assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
    assign done_edge = gcd_done && !done_prev;
    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign gcd_x     = op_x;
    assign gcd_y     = op_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_x      <= '0;
            op_y      <= '0;
            done_prev <= 1'b0;
            tmo_cnt   <= '0;
            gcd_start <= 1'b0;
            res_valid <= 1'b0;
            res_x     <= '0;
            res_y     <= '0;
            res_gcd   <= '0;
            res_err   <= 1'b0;
        end else begin
            // Tracked every cycle so a DONE left high from an earlier run is not seen as an edge.
            done_prev <= gcd_done;
            gcd_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_x  <= fifo_rdata[2*OPW-1:OPW];
                        op_y  <= fifo_rdata[OPW-1:0];
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (has_zero(op_x, op_y)) begin
                        res_x     <= op_x;
                        res_y     <= op_y;
                        res_gcd   <= op_x | op_y;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        gcd_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion edge on the final timeout cycle still counts as a result.
                    if (done_edge) begin
                        res_x     <= op_x;
                        res_y     <= op_y;
                        res_gcd   <= gcd_result;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_x     <= op_x;
                        res_y     <= op_y;
                        res_gcd   <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
